rvfi_trace_buffer: RTL

RVFI_TRACE_BUFFER -- requirements
Module: rvfi_trace_buffer

---
 rtl/rvfi_trace_buffer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rvfi_trace_buffer.sv
// RVFI retire trace FIFO: captures up to NRET retired-instruction packets per cycle, tags each
// with a 64-bit retire order number. Memory fields are included when RVFI_TRACE_MEM_EN is defined.
module rvfi_trace_buffer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned NRET  = 1,
`ifdef RVFI_TRACE_MEM_EN
   localparam int unsigned MEM_W = 3*XLEN + XLEN/4,
`else
   localparam int unsigned MEM_W = 0,
`endif
   localparam int unsigned PKT_W = 38 + 3*XLEN + MEM_W,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NRET-1:0]         in_valid,
   input  logic [NRET*PKT_W-1:0]   in_pkt,
   input  logic                    halt,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [PKT_W-1:0]        out_pkt,
   output logic [63:0]             out_order,
   output logic [CW-1:0]           count,
   output logic                    overflow
);

   localparam int unsigned RDW_LSB  = 2*XLEN;
   localparam int unsigned RDA_LSB  = 3*XLEN;
   localparam int unsigned TRAP_BIT = 3*XLEN + 37;
`ifdef RVFI_TRACE_MEM_EN
   localparam int unsigned WMASK_LSB = 38 + 5*XLEN;
   localparam int unsigned RMASK_LSB = WMASK_LSB + XLEN/8;
`endif

   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [63:0]      order_q;
   logic             overflow_q;
   logic [PKT_W-1:0] pkt_mem [DEPTH];
   logic [63:0]      ord_mem [DEPTH];

   logic [1:0]       n_valid;
   logic [NRET-1:0]  lane_we;
   logic [AW-1:0]    lane_slot  [NRET];
   logic [63:0]      lane_order [NRET];
   logic [PKT_W-1:0] lane_pkt   [NRET];
   logic [CW-1:0]    free;
   logic             capture, accept, drop, pop;

   always_comb begin
      n_valid = '0;
      for (int k = 0; k < NRET; k++) begin
         // Lanes pack densely: each valid lane takes the next slot and order number.
         lane_slot[k]  = wr_ptr_q + AW'(n_valid);
         lane_order[k] = order_q + 64'(n_valid);
         lane_pkt[k]   = in_pkt[k*PKT_W +: PKT_W];
         if (lane_pkt[k][RDA_LSB +: 5] == 5'd0 || lane_pkt[k][TRAP_BIT]) begin
            lane_pkt[k][RDW_LSB +: XLEN] = '0;
         end
`ifdef RVFI_TRACE_MEM_EN
         if (lane_pkt[k][TRAP_BIT]) begin
            lane_pkt[k][WMASK_LSB +: XLEN/8] = '0;
            lane_pkt[k][RMASK_LSB +: XLEN/8] = '0;
         end
`endif
         if (in_valid[k]) begin
            n_valid = n_valid + 2'd1;
         end
      end
      capture = !halt && !flush;
      // Room is judged on the start-of-cycle count; a same-cycle pop does not help.
      free    = CW'(DEPTH) - count_q;
      accept  = capture && (n_valid != 2'd0) && (CW'(n_valid) <= free);
      drop    = capture && (CW'(n_valid) > free);
      pop     = out_valid && out_ready && !flush;
      lane_we = in_valid & {NRET{accept}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         order_q    <= '0;
         overflow_q <= 1'b0;
      end else if (flush) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr_q <= wr_ptr_q + AW'(n_valid);
            order_q  <= order_q + 64'(n_valid);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + (accept ? CW'(n_valid) : CW'(0)) - CW'(pop);
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NRET; k++) begin
         if (lane_we[k]) begin
            pkt_mem[lane_slot[k]] <= lane_pkt[k];
            ord_mem[lane_slot[k]] <= lane_order[k];
         end
      end
   end

   assign count     = count_q;
   assign overflow  = overflow_q;
   assign out_valid = (count_q != '0);
   // Storage is not reset, so the head is masked while empty.
   assign out_pkt   = out_valid ? pkt_mem[rd_ptr_q] : '0;
   assign out_order = out_valid ? ord_mem[rd_ptr_q] : '0;

endmodule
